// File: rtl/map_switch_seq.sv
// map_switch_seq: glitch-free runtime mapper switch (M2-aligned hold, reset, swap, settle).
// Define MAP_SWITCH_SS_EN to let ss_busy block new requests and stall the M2 wait.
module map_switch_seq #(
    parameter int          HOLD_CYC   = 4,
    parameter int          RST_CYC    = 8,
    parameter int          SETTLE_CYC = 16,
    parameter int          TMO_CYC    = 1024,
    parameter logic [7:0]  BOOT_IDX   = 8'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m2,
    input  logic       req_valid,
    input  logic [7:0] req_idx,
    output logic       req_ready,
    output logic [7:0] map_idx,
    output logic       map_hold,
    output logic       map_rst,
    output logic       busy,
    output logic       done,
    output logic       unsup,
    output logic       tmo,
    input  logic       ss_busy
);
    localparam int M_A = HOLD_CYC > RST_CYC ? HOLD_CYC : RST_CYC;
    localparam int M_B = SETTLE_CYC > TMO_CYC ? SETTLE_CYC : TMO_CYC;
    localparam int M_C = M_A > M_B ? M_A : M_B;
    localparam int CW  = M_C > 2 ? $clog2(M_C) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_M2, HOLD, RST, SETTLE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, lim;
    logic [7:0]    pend_idx;
    logic          m2_s1, m2_s2, m2_s3;
    logic          fall, stall, accept, supported, at_lim, tmo_hit;

`ifdef MAP_SWITCH_SS_EN
    assign req_ready = state == IDLE && !ss_busy;
    assign stall     = ss_busy;
`else
    logic unused_ss;
    assign unused_ss = ss_busy;
    assign req_ready = state == IDLE;
    assign stall     = 1'b0;
`endif

    assign busy      = state != IDLE;
    assign accept    = req_valid && req_ready;
    assign fall      = m2_s3 && !m2_s2;
    assign supported = req_idx inside {8'd56, 8'd103, 8'd132, 8'd134, 8'd136, 8'd172,
                                       8'd173, 8'd186, 8'd187, 8'd198, 8'd221, 8'd254};
    // One counter serves every timed state; its limit follows the current state.
    assign lim    = state == HOLD   ? CW'(HOLD_CYC - 1) :
                    state == RST    ? CW'(RST_CYC - 1) :
                    state == SETTLE ? CW'(SETTLE_CYC - 1) : CW'(TMO_CYC - 1);
    assign at_lim = cnt == lim;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tmo_hit  = 1'b0;
        case (state)
            IDLE: begin
                state_nx = accept ? WAIT_M2 : IDLE;
                cnt_nx   = '0;
            end
            WAIT_M2: begin
                if (!stall) begin
                    state_nx = fall || at_lim ? HOLD : WAIT_M2;
                    cnt_nx   = fall || at_lim ? '0 : cnt + 1'b1;
                    tmo_hit  = at_lim && !fall;
                end
            end
            HOLD: begin
                state_nx = at_lim ? RST : HOLD;
                cnt_nx   = at_lim ? '0 : cnt + 1'b1;
            end
            RST: begin
                state_nx = at_lim ? SETTLE : RST;
                cnt_nx   = at_lim ? '0 : cnt + 1'b1;
            end
            SETTLE: begin
                state_nx = at_lim ? IDLE : SETTLE;
                cnt_nx   = at_lim ? '0 : cnt + 1'b1;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            {m2_s3, m2_s2, m2_s1} <= 3'b000;
            pend_idx <= 8'd0;
            map_idx  <= BOOT_IDX;
            map_hold <= 1'b0;
            map_rst  <= 1'b0;
            done     <= 1'b0;
            unsup    <= 1'b0;
            tmo      <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            {m2_s3, m2_s2, m2_s1} <= {m2_s2, m2_s1, m2};
            map_hold <= state_nx inside {HOLD, RST, SETTLE};
            map_rst  <= state_nx == RST;
            done     <= state == SETTLE && state_nx == IDLE;
            if (accept) begin
                pend_idx <= supported ? req_idx : 8'd0;
                unsup    <= !supported;
                tmo      <= 1'b0;
            end
            if (tmo_hit)
                tmo <= 1'b1;
            // Swap only as map_rst rises so the hub never sees a new index on live mapper state.
            if (state == HOLD && state_nx == RST)
                map_idx <= pend_idx;
        end
    end
endmodule

// File: tb/tb_map_switch_seq.sv
// tb_map_switch_seq: randomized + directed bench with a schedule-based reference model.
// Build with MAP_SWITCH_SS_EN defined to also exercise the save-state gating.
module tb_map_switch_seq;
    localparam int H = 4, R = 8, S = 16, T = 1024, NH = 20000;

    logic       clk = 1'b0, rst_n = 1'b0, m2 = 1'b0, req_valid = 1'b0, ss_busy = 1'b0;
    logic [7:0] req_idx = 8'd0;
    logic       req_ready, map_hold, map_rst, busy, done, unsup, tmo;
    logic [7:0] map_idx;

    int tests = 0, fails = 0;
    int m2_mode = 0;
    bit chk_en = 0;

    map_switch_seq dut (
        .clk(clk), .rst_n(rst_n), .m2(m2), .req_valid(req_valid), .req_idx(req_idx),
        .req_ready(req_ready), .map_idx(map_idx), .map_hold(map_hold), .map_rst(map_rst),
        .busy(busy), .done(done), .unsup(unsup), .tmo(tmo), .ss_busy(ss_busy)
    );

    always #5 clk = ~clk;

    // Reference model: m2 history plus a timeline measured from the last WAIT_M2 cycle.
    bit         m2h [0:NH-1];
    int         ncyc = 0, rel = 0, mode = 0, wc = 0, e = 0;
    logic [7:0] pend = 8'd0, x_idx = 8'd0;
    logic       x_hold = 0, x_rst = 0, x_done = 0, x_unsup = 0, x_tmo = 0;
    int         sup_list [12] = '{56, 103, 132, 134, 136, 172, 173, 186, 187, 198, 221, 254};

    function automatic bit is_sup(logic [7:0] v);
        foreach (sup_list[i]) if (v == 8'(sup_list[i])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit s2(int k);
        return (k >= 2 && k - 2 >= rel && k - 2 < NH) ? m2h[k-2] : 1'b0;
    endfunction

    function automatic bit x_ready();
`ifdef MAP_SWITCH_SS_EN
        return mode == 0 && !ss_busy;
`else
        return mode == 0;
`endif
    endfunction

    function automatic bit stalled();
`ifdef MAP_SWITCH_SS_EN
        return ss_busy;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        mode = 0; wc = 0; x_idx = 8'd0; x_hold = 0; x_rst = 0; x_done = 0; x_unsup = 0; x_tmo = 0;
    endtask

    task automatic model_step();
        int d;
        if (ncyc < NH) m2h[ncyc] = m2;
        if (!rst_n) begin
            model_reset();
            rel = ncyc + 1;
        end else begin
            x_done = 0;
            if (mode == 0 && req_valid && x_ready()) begin
                pend = is_sup(req_idx) ? req_idx : 8'd0;
                x_unsup = !is_sup(req_idx);
                x_tmo = 0;
                mode = 1;
                wc = 0;
            end else if (mode == 1 && !stalled()) begin
                if (s2(ncyc - 1) && !s2(ncyc)) begin
                    mode = 2; e = ncyc;
                end else if (wc == T - 1) begin
                    mode = 2; e = ncyc; x_tmo = 1;
                end else wc++;
            end
        end
        ncyc++;
        if (rst_n && mode == 2) begin
            d = ncyc - e;
            x_hold = d <= H + R + S;
            x_rst = d > H && d <= H + R;
            if (d == H + 1) x_idx = pend;
            if (d == H + R + S + 1) begin
                x_done = 1;
                mode = 0;
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, ncyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("map_idx", 32'(map_idx), 32'(x_idx));
            chk("map_hold", 32'(map_hold), 32'(x_hold));
            chk("map_rst", 32'(map_rst), 32'(x_rst));
            chk("done", 32'(done), 32'(x_done));
            chk("unsup", 32'(unsup), 32'(x_unsup));
            chk("tmo", 32'(tmo), 32'(x_tmo));
            chk("busy", 32'(busy), 32'(mode != 0));
            chk("req_ready", 32'(req_ready), 32'(x_ready()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        if (m2_mode == 1 && ncyc % 3 == 0) m2 = ~m2;
        else if (m2_mode == 2 && $urandom_range(0, 2) == 0) m2 = ~m2;
    endtask

    task automatic accept_req(logic [7:0] idx);
        req_valid = 1'b1;
        req_idx = idx;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int k);
        k = 1;
        while (!done && k < lim) begin
            cyc();
            k++;
        end
    endtask

    task automatic wait_sig(input bit want_rst, input int lim);
        int k = 0;
        while (map_rst != want_rst && k < lim) begin
            cyc();
            k++;
        end
        chk("wait_map_rst", 32'(map_rst), 32'(want_rst));
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hk, rk, dk, nr, nd, pre_idx;
        logic [7:0] ridx;
        repeat (3) cyc();
        chk_en = 1;
        rst_n = 1'b1;
        cyc();
        chk("rel_idx", 32'(map_idx), 0);
        chk("rel_hold", 32'(map_hold), 0);
        chk("rel_rst", 32'(map_rst), 0);
        chk("rel_ready", 32'(req_ready), 1);
        chk("rel_busy", 32'(busy), 0);

        // 221 with M2 falling on the 5th edge after accept
        m2 = 1'b1;
        repeat (4) cyc();
        accept_req(8'd221);
        hk = 0; rk = 0; dk = 0; nr = 0; ridx = 8'd0; pre_idx = -1;
        for (int k = 1; k <= 40; k++) begin
            if (map_hold && hk == 0) hk = k;
            if (map_rst) begin
                if (rk == 0) begin rk = k; ridx = map_idx; end
                nr++;
            end
            if (k == 10) pre_idx = int'(map_idx);
            if (done) dk = k;
            if (k == 4) m2 = 1'b0;
            cyc();
        end
        chk("d221_hold_rise", hk, 7);
        chk("d221_rst_first", rk, 11);
        chk("d221_rst_len", nr, 8);
        chk("d221_idx_at_rst", 32'(ridx), 221);
        chk("d221_idx_pre_rst", pre_idx, 0);
        chk("d221_done", dk, 35);
        chk("d221_unsup", 32'(unsup), 0);
        chk("d221_tmo", 32'(tmo), 0);

        // 57 (unsupported) with M2 stuck low: timeout path
        accept_req(8'd57);
        wait_done(1200, dk);
        chk("d57_done", dk, 1 + 1024 + 28);
        chk("d57_tmo", 32'(tmo), 1);
        chk("d57_unsup", 32'(unsup), 1);
        chk("d57_idx", 32'(map_idx), 0);

        // 172 with a 56 request arriving mid-RST
        m2_mode = 1;
        accept_req(8'd172);
        wait_sig(1'b1, 200);
        cyc();
        accept_req(8'd56);
        nd = 0;
        for (int k = 0; k < 80; k++) begin
            if (done) nd++;
            cyc();
        end
        chk("d172_dones", nd, 1);
        chk("d172_idx", 32'(map_idx), 172);

        // reset during SETTLE of 0 -> 134
        assert_reset();
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        accept_req(8'd134);
        wait_sig(1'b1, 200);
        wait_sig(1'b0, 40);
        cyc(); cyc(); cyc();
        chk("d134_in_settle", 32'(map_hold), 1);
        assert_reset();
        chk("d134_rst_hold", 32'(map_hold), 0);
        chk("d134_rst_rst", 32'(map_rst), 0);
        chk("d134_rst_idx", 32'(map_idx), 0);
        chk("d134_rst_busy", 32'(busy), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

`ifdef MAP_SWITCH_SS_EN
        // ss_busy blocks acceptance in IDLE
        ss_busy = 1'b1;
        req_valid = 1'b1;
        req_idx = 8'd56;
        repeat (3) cyc();
        chk("ss_ready", 32'(req_ready), 0);
        chk("ss_not_taken", 32'(busy), 0);
        req_valid = 1'b0;
        ss_busy = 1'b0;
        cyc();
        // ss_busy stalls WAIT_M2 for 50 cycles
        m2_mode = 0;
        m2 = 1'b1;
        repeat (4) cyc();
        accept_req(8'd221);
        ss_busy = 1'b1;
        dk = 0;
        for (int k = 1; k <= 120; k++) begin
            if (k == 51) ss_busy = 1'b0;
            if (k == 54) m2 = 1'b0;
            if (done && dk == 0) dk = k;
            cyc();
        end
        chk("ss_done_delay", dk, 85);
        chk("ss_tmo", 32'(tmo), 0);
        chk("ss_idx", 32'(map_idx), 221);
`endif

        // randomized traffic
        m2_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            req_valid = $urandom_range(0, 5) == 0;
            req_idx = $urandom_range(0, 1) ? 8'(sup_list[$urandom_range(0, 11)]) : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) ss_busy = ~ss_busy;
            if ($urandom_range(0, 799) == 0) begin
                assert_reset();
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end
        req_valid = 1'b0;
        ss_busy = 1'b0;
        repeat (40) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/map_switch_seq.md
Name: map_switch_seq

Overview:
- Runtime mapper-switch sequencer in front of the mapper hub.
- Owns the registered mapper index that drives hub selection.
- Accepts a switch request, waits for a CPU-cycle boundary, holds the cartridge bus, resets the mappers, swaps the index, lets the design settle, then releases.
- Prevents glitched map_out selection during multicart/menu mapper changes.

Parameters:
- HOLD_CYC, 4, clk cycles map_hold is asserted before map_rst (min 1)
- RST_CYC, 8, clk cycles map_rst is asserted (min 1)
- SETTLE_CYC, 16, clk cycles after map_rst release before map_hold drops (min 1)
- TMO_CYC, 1024, max clk cycles to wait for an M2 falling edge
- BOOT_IDX, 0, map_idx value after reset

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m2  in  1  CPU phi2, asynchronous to clk; 2-flop synchronised internally
- req_valid  in  1  switch request
- req_idx  in  8  requested mapper index
- req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready
- map_idx  out  8  registered mapper index to hub
- map_hold  out  1  hub forces nominal/inactive output while high
- map_rst  out  1  mapper register reset while high
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on return to IDLE
- unsup  out  1  sticky: last accepted req_idx not in supported set
- tmo  out  1  sticky: last WAIT_M2 ended by timeout
- ss_busy  in  1  save-state engine active (used only with option)

Behaviour:
- Reset, async, rst_n low: state=IDLE, map_idx=BOOT_IDX, map_hold=0, map_rst=0, done=0, unsup=0, tmo=0, counters=0, m2 sync flops=0.
- Supported set: {56,103,132,134,136,172,173,186,187,198,221,254}.
  - Any other req_idx latches as 0 (nominal) and sets unsup.
  - unsup and tmo clear on the next accepted request.
- Falling edge of M2: synchronised m2 was 1 last cycle and is 0 this cycle.
- IDLE:
  - req_ready=1.
  - On accept: latch pend_idx, compute unsup, clear tmo, go to WAIT_M2 next cycle.
- WAIT_M2:
  - Count cycles.
  - On a detected M2 falling edge, go to HOLD.
  - If count reaches TMO_CYC-1 with no edge, set tmo and go to HOLD.
  - An edge on the same cycle as the timeout counts as an edge; tmo stays 0.
- HOLD:
  - map_hold=1 for exactly HOLD_CYC cycles, then RST.
- RST:
  - map_hold=1 and map_rst=1 for exactly RST_CYC cycles.
  - map_idx<=pend_idx on the first RST cycle, so the index changes only while map_rst is high.
- SETTLE:
  - map_hold=1, map_rst=0 for SETTLE_CYC cycles.
  - Then IDLE with done=1 for one cycle.
- map_hold is registered and is high from the first HOLD cycle through the last SETTLE cycle, with no gaps.
- Total latency from accept to done = 1 + WAIT_M2 cycles + HOLD_CYC + RST_CYC + SETTLE_CYC.
- req_valid while busy is ignored: no queueing, no error.
- Requesting the current map_idx runs the full sequence; mapper state is re-initialised.
- Counters size to clog2 of the largest parameter; no wrap is reachable.
- rst_n asserted mid-sequence: immediate return to reset values.
  - map_idx reverts to BOOT_IDX.
  - The pending request is discarded.

Optional Feature:
- Macro: MAP_SWITCH_SS_EN.
- Defined:
  - req_ready = IDLE & ~ss_busy.
  - In WAIT_M2, a rising ss_busy stalls the timeout counter and edge detection until ss_busy drops.
  - HOLD/RST/SETTLE are not interruptible by ss_busy.
- Undefined:
  - ss_busy is ignored.
  - req_ready = IDLE only.

Test Plan:
- Reset release, rst_n 0→1 → map_idx=0, map_hold=0, map_rst=0, req_ready=1, busy=0.
- req_idx=221 with M2 toggling (first falling edge 5 cycles after accept), defaults →
  - map_hold rises on accept+7.
  - map_rst high for 8 cycles; map_idx=221 on its first cycle.
  - done at accept+35.
  - unsup=0, tmo=0.
- req_idx=57, M2 stuck low →
  - tmo=1 after 1024 WAIT_M2 cycles.
  - map_idx=0, unsup=1.
  - done at accept+1+1024+28.
- Second req_valid (idx 56) mid-RST of a 172 switch → ignored; final map_idx=172; single done.
- rst_n low during SETTLE of a switch from 0 to 134 → immediate map_hold=0, map_rst=0, map_idx=0, busy=0.
- With MAP_SWITCH_SS_EN defined:
  - ss_busy=1 in IDLE → req_ready=0, request not taken.
  - ss_busy high for 50 cycles in WAIT_M2 → done delayed by 50 cycles; tmo=0.
